// File: rtl/gate_unit_pkg.sv
// Shared definitions for gate_unit: the operation codes and the width of the op select.
package gate_unit_pkg;

   localparam int unsigned GATE_OP_W = 3;

   typedef enum logic [GATE_OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASS = 3'd7
   } gate_op_e;

endpackage

// File: rtl/gate_unit_alu.sv
// Combinational WIDTH-bit logic function selected by op.
module gate_unit_alu
   import gate_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [GATE_OP_W-1:0] op,
   output logic [WIDTH-1:0]     y
);

   always_comb begin
      y = '0;
      case (gate_op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/gate_unit.sv
// Registered logic unit with a one-deep valid/ready output stage and a saturating non-zero counter.
// GATE_UNIT_REDUCE_EN builds the registered q_any/q_all/q_par reductions; otherwise they are tied to 0.
module gate_unit
   import gate_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [GATE_OP_W-1:0] op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     q,
   output logic                 q_any,
   output logic                 q_all,
   output logic                 q_par,
   output logic [CNT_W-1:0]     nz_cnt,
   input  logic                 cnt_clr
);

   logic [WIDTH-1:0] y;
   logic             in_fire;
   logic             out_fire;

   gate_unit_alu #(.WIDTH(WIDTH)) u_alu (
      .a  (a),
      .b  (b),
      .op (op),
      .y  (y)
   );

   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= '0;
         out_valid <= 1'b0;
      end else if (in_fire) begin
         q         <= y;
         out_valid <= 1'b1;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   // Clear wins over a coinciding count; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nz_cnt <= '0;
      end else if (cnt_clr) begin
         nz_cnt <= '0;
      end else if (out_fire && (q != '0) && (nz_cnt != '1)) begin
         nz_cnt <= nz_cnt + 1'b1;
      end
   end

`ifdef GATE_UNIT_REDUCE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_any <= 1'b0;
         q_all <= 1'b0;
         q_par <= 1'b0;
      end else if (in_fire) begin
         q_any <= |y;
         q_all <= &y;
         q_par <= ^y;
      end
   end
`else
   assign q_any = 1'b0;
   assign q_all = 1'b0;
   assign q_par = 1'b0;
`endif

endmodule

// File: tb/tb_gate_unit.sv
// Randomised and directed bench for gate_unit with a queue scoreboard and a behavioural model.
module tb_gate_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, out_ready, cnt_clr;
   logic [7:0] a, b;
   logic [2:0] op;

   logic        in_ready, out_valid, q_any, q_all, q_par;
   logic [7:0]  q;
   logic [15:0] nz_cnt;
   logic        in_ready2, out_valid2, q_any2, q_all2, q_par2;
   logic [7:0]  q2;
   logic [1:0]  nz_cnt2;

   int checks = 0;
   int errors = 0;
   int delivered = 0;
   logic [7:0] sb[$];
   int exp_cnt = 0;
   int exp_cnt2 = 0;

   always #5 clk = ~clk;

   gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .q(q), .q_any(q_any), .q_all(q_all), .q_par(q_par),
      .nz_cnt(nz_cnt), .cnt_clr(cnt_clr)
   );

   gate_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
      .q(q2), .q_any(q_any2), .q_all(q_all2), .q_par(q_par2),
      .nz_cnt(nz_cnt2), .cnt_clr(cnt_clr)
   );

   function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      case (o)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return x ^ z;
         3'd3:    return ~(x & z);
         3'd4:    return ~(x | z);
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compares q against the queued model result, tracks the counter model.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst_n) begin
         chk("rst_q", q, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_nz_cnt", nz_cnt, 0);
         chk("rst_reduce", {q_any, q_all, q_par}, 0);
         sb.delete();
         exp_cnt  = 0;
         exp_cnt2 = 0;
      end else begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         chk("nz_cnt", nz_cnt, exp_cnt);
         chk("nz_cnt_sat", nz_cnt2, exp_cnt2);
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got q=%0h with no result pending", q);
            end else begin
               e = sb[0];
               chk("q", q, e);
`ifdef GATE_UNIT_REDUCE_EN
               chk("reduce", {q_any, q_all, q_par}, {|e, &e, ^e});
`else
               chk("reduce", {q_any, q_all, q_par}, 0);
`endif
               if (out_ready) begin
                  void'(sb.pop_front());
                  delivered++;
                  if (e != 0) begin
                     if (exp_cnt < 65535) exp_cnt++;
                     if (exp_cnt2 < 3) exp_cnt2++;
                  end
               end
            end
         end
         if (cnt_clr) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
         end
         if (in_valid && in_ready) sb.push_back(ref_f(op, a, b));
      end
   end

   // Called just after a rising edge; returns just after the accepting edge with in_valid dropped.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
      int n = 0;
      in_valid = 1'b1; a = ia; b = ib; op = iop;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tbl[8];
      int d0;
      tbl = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      a = '0; b = '0; op = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("idle_q", q, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_nz_cnt", nz_cnt, 0);

      // All eight operations
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(8'hC3, 8'hA5, 3'(i));
         chk("op_table", q, tbl[i]);
         if (i == 0) chk("par_of_81", q_par, 0);
      end
      @(posedge clk);

      // Back-pressure with a queued second input
      #1 out_ready = 1'b0;
      issue(8'h0F, 8'hF0, 3'd1);
      in_valid = 1'b1; a = 8'h33; b = 8'h0F; op = 3'd2;
      repeat (3) begin
         @(negedge clk);
         chk("bp_q_hold", q, 8'hFF);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_queued_load", q, 8'h3C);
      @(posedge clk);

      // Streaming
      #1 d0 = delivered;
      in_valid = 1'b1; op = 3'd2; a = 8'($urandom); b = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (i < 9) begin
            a = 8'($urandom); b = 8'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk("stream_valid", out_valid, 1);
      end
      @(posedge clk);
      @(negedge clk);
      chk("stream_count", delivered - d0, 10);

      // Counter: 5 deliveries with 2 zero results
      @(posedge clk);
      #1 cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      issue(8'h01, 8'h00, 3'd1);
      issue(8'h5A, 8'h5A, 3'd2);
      issue(8'h80, 8'h00, 3'd1);
      issue(8'h77, 8'h77, 3'd2);
      issue(8'h10, 8'h01, 3'd2);
      @(posedge clk);
      #1 chk("cnt_three", nz_cnt, 3);

      // Clear coinciding with a non-zero delivery
      issue(8'h01, 8'h00, 3'd1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      chk("cnt_clr_priority", nz_cnt, 0);

      // Saturation of the 2-bit counter
      for (int i = 0; i < 6; i++) issue(8'(i + 1), 8'h00, 3'd1);
      @(posedge clk);
      #1 chk("cnt_sat", nz_cnt2, 3);
      chk("cnt_six", nz_cnt, 6);

      // Reset while a result is stalled
      out_ready = 1'b0;
      issue(8'hAA, 8'h55, 3'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_valid", out_valid, 0);
      chk("async_rst_q", q, 0);
      chk("async_rst_ready", in_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         a  = 8'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
         op = 3'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_unit.md
# gate_unit

Parametrised, registered bitwise logic unit: the multi-function, multi-bit successor of the two-input OR gate. It applies one of eight selectable logic operations to two `WIDTH`-bit operands and holds the result in an output register behind a valid/ready handshake. It also keeps a saturating count of delivered non-zero results. It sits between a operand source (switches, UART decoder or test sequencer) and any consumer that needs back-pressure.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.
- `CNT_W`, default 16: width of the non-zero result counter.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and `op` are valid this cycle.
- `in_ready` output 1: unit accepts operands this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `op` input 3: operation select, sampled with operands.
- `out_valid` output 1: `q` holds an undelivered result.
- `out_ready` input 1: consumer accepts `q` this cycle.
- `q` output WIDTH: registered result.
- `q_any`, `q_all`, `q_par` output 1 each: reductions of `q` (OR, AND, XOR); see Configuration.
- `nz_cnt` output CNT_W: count of delivered results with `q != 0`.
- `cnt_clr` input 1: synchronous clear of `nz_cnt`.

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (b ignored), 7 PASS A.
- Input transfer occurs when `in_valid && in_ready`. Result `f(op,a,b)` loads into `q` and sets `out_valid`.
- Output transfer occurs when `out_valid && out_ready`. If there is no simultaneous input transfer, `out_valid` clears.
- `in_ready = !out_valid || out_ready` (combinational). This gives a one-deep buffer with pass-through back-pressure, sustaining full throughput.
- Simultaneous input and output transfer: the new result replaces `q` and `out_valid` stays 1.
- While `out_valid && !out_ready`, `q`, `out_valid` and the reductions hold stable. `in_ready` is 0.
- Operands and `op` are don't-care when `in_valid=0`; `q` does not change.
- `nz_cnt` increments by 1 on each output transfer where `q != 0`.
  - It saturates at all-ones and never wraps.
  - `cnt_clr` has priority: a clear coinciding with a counting transfer yields 0.
- Reset (asserted at any time, including mid-transfer) clears everything immediately. `out_valid`=0, `q`=0, `nz_cnt`=0, reductions=0; `in_ready` therefore becomes 1. The pending result is discarded.

## Timing
- Latency: result visible on `q` one cycle after the accepting edge.
- Throughput: one result per cycle when `out_ready` is held 1.
- `in_ready` depends combinationally on `out_ready`; there are no other combinational in-to-out paths.
- Reductions are registered alongside `q`, with the same timing. They are not derived combinationally from `q`.
- `nz_cnt` updates on the edge that completes the output transfer.
- Reset values: `q`=0, `out_valid`=0, `q_any`=`q_all`=`q_par`=0, `nz_cnt`=0, `in_ready`=1.

## Configuration
- Macro `GATE_UNIT_REDUCE_EN`.
- Defined: the reduction registers are built.
  - `q_any` = |result, `q_all` = &result, `q_par` = ^result.
  - They load with `q` and hold with `q`.
- Undefined: the reduction registers are not built, and the three ports are tied to 0 permanently. Ports remain present so instantiations are identical in both builds.

## Structure
- Package `gate_unit_pkg`: enum `gate_op_e` (the eight op codes above) and constant `GATE_OP_W = 3`.
- One sub-module `gate_unit_alu`: purely combinational `WIDTH`-bit op mux `(a, b, op) -> y`.
- The top level owns the handshake register, the reductions and the counter.

## Test plan
- Reset then idle: `rst_n` low, then high; check `q`=0, `out_valid`=0, `in_ready`=1, `nz_cnt`=0.
- All ops, `WIDTH`=8, a=8'hC3, b=8'hA5, op 0..7 with `out_ready`=1. Expected `q`, each 1 cycle after issue:
  - 8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3.
  - With the macro, `q_par` for the 8'h81 result is 0.
- Back-pressure: issue a=8'h0F, b=8'hF0, op=1, with `out_ready`=0 for 3 cycles.
  - `q`=8'hFF holds, `in_ready`=0, and a second `in_valid` is not accepted.
  - Raise `out_ready`: the transfer completes and the queued input loads the next cycle.
- Streaming: 10 back-to-back XOR ops with `in_valid`=`out_ready`=1; expect 10 results on consecutive cycles and `out_valid` continuously 1.
- Counter:
  - Deliver 5 results, 2 of them zero (a=b, op=2); expect `nz_cnt`=3.
  - Assert `cnt_clr` during a non-zero delivery; expect `nz_cnt`=0.
  - With `CNT_W`=2, deliver 6 non-zero results; expect `nz_cnt`=3, saturated.
- Reset mid-operation: assert `rst_n` low while `out_valid`=1 and `out_ready`=0; expect `out_valid`=0 and `q`=0 immediately, without waiting for a clock edge.
